// File: rtl/seq_arith_mul.sv
// seq_arith_mul: multi-cycle shift-add unsigned multiplier with valid/ready on both sides.
// Define SEQ_ARITH_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_arith_mul #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d, acc_sum;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last;
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_prod  = prod_q;
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_ARITH_MUL_EARLY_EXIT_EN
    assign last = cnt_q == CNT_W'(WIDTH - 1) || (mplier_q >> 1) == '0;
`else
    assign last = cnt_q == CNT_W'(WIDTH - 1);
`endif
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                mcand_d  = {{WIDTH{1'b0}}, in_a};
                mplier_d = in_b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                prod_d   = last ? acc_sum : prod_q;
                state_d  = last ? DONE : RUN;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end
endmodule

// File: tb/tb_seq_arith_mul.sv
// tb_seq_arith_mul: directed checks of seq_arith_mul at WIDTH=4.
// Latency expectations follow SEQ_ARITH_MUL_EARLY_EXIT_EN when it is defined.
module tb_seq_arith_mul;
    localparam int WIDTH = 4;
    logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic in_ready, out_valid, busy;
    logic [WIDTH-1:0] in_a = 0, in_b = 0;
    logic [2*WIDTH-1:0] out_prod;
    int checks = 0, errors = 0;

    seq_arith_mul #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [WIDTH-1:0] b);
`ifdef SEQ_ARITH_MUL_EARLY_EXIT_EN
        int l = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) l = i + 1;
        return l;
`else
        return WIDTH;
`endif
    endfunction

    // Called right after the accept edge; counts edges until out_valid rises.
    task automatic wait_result(input string tag, input int exp, input int exp_lat, input bit scramble);
        int n = 0;
        while (!out_valid && n <= 20) begin
            chk({tag, "_ready_busy"}, int'(in_ready && busy), 0);
            if (scramble) begin
                in_a = WIDTH'($urandom);
                in_b = WIDTH'($urandom);
            end
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_prod"}, int'(out_prod), exp);
    endtask

    task automatic accept(input string tag, input int a, input int b);
        in_a = WIDTH'(a);
        in_b = WIDTH'(b);
        in_valid = 1;
        chk({tag, "_in_ready_pre"}, int'(in_ready), 1);
        tick();
        in_valid = 0;
        chk({tag, "_in_ready_post"}, int'(in_ready), 0);
        chk({tag, "_busy_post"}, int'(busy), 1);
    endtask

    task automatic mul(input string tag, input int a, input int b, input int exp);
        accept(tag, a, b);
        wait_result(tag, exp, lat(WIDTH'(b)), 0);
        tick();
        chk({tag, "_idle_valid"}, int'(out_valid), 0);
        chk({tag, "_idle_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_prod", int'(out_prod), 0);
        reset = 0;
        out_ready = 1;
        tick();

        mul("max", 15, 15, 225);

        out_ready = 0;
        accept("bp", 9, 6);
        wait_result("bp", 54, lat(4'd6), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_prod", int'(out_prod), 54);
        end
        out_ready = 1;
        in_valid = 1;
        in_a = 2;
        in_b = 7;
        tick();
        chk("bp_hs_valid", int'(out_valid), 0);
        chk("bp_no_same_accept", int'(busy), 0);
        tick();
        in_valid = 0;
        chk("bp_next_accept", int'(busy), 1);
        wait_result("bp2", 14, lat(4'd7), 0);
        tick();

        mul("s0", 3, 5, 15);
        mul("s1", 0, 11, 0);
        mul("s2", 7, 0, 0);
        mul("s3", 1, 1, 1);

        accept("rst", 12, 13);
        tick();
        reset = 1;
        tick();
        reset = 0;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        chk("rst_mid_busy", int'(busy), 0);
        mul("after_rst", 2, 3, 6);

        accept("scr", 10, 10);
        wait_result("scr", 100, lat(4'd10), 1);
        tick();

`ifdef SEQ_ARITH_MUL_EARLY_EXIT_EN
        mul("ee_13x1", 13, 1, 13);
        mul("ee_13x0", 13, 0, 0);
        mul("ee_13x8", 13, 8, 104);
        chk("ee_lat1", lat(4'd1), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
